// File: rtl/ip_psum_ctrl_if.sv
// Chunk and result handshake bundle between the partial-sum
// sequencer, the ip stage and the downstream consumer.
interface ip_psum_ctrl_if #(
   parameter int bitwidth = 8
);
   logic                chunk_valid;
   logic                chunk_ready;
   logic [bitwidth-1:0] sum;
   logic [bitwidth-1:0] psum;
   logic                sel;
   logic                res_valid;
   logic                res_ready;
   logic [bitwidth-1:0] res_data;

   modport master (
      output chunk_valid, sum, res_ready,
      input  chunk_ready, psum, sel, res_valid, res_data
   );

   modport slave (
      input  chunk_valid, sum, res_ready,
      output chunk_ready, psum, sel, res_valid, res_data
   );
endinterface

// File: rtl/ip_psum_ctrl.sv
// Partial-sum sequencer around the ip stage: chains chunk sums
// through the psum register and presents the final dot product.
module ip_psum_ctrl #(
   parameter int bitwidth  = 8,
   parameter int cnt_width = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 start,
   input  logic [cnt_width-1:0] num_chunks,
   output logic                 busy,
   ip_psum_ctrl_if.slave        bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t               state, state_d;
   logic [cnt_width-1:0] n_q, n_d;
   logic [cnt_width-1:0] cnt, cnt_d;
   logic [bitwidth-1:0]  psum_q, psum_d;
   logic [bitwidth-1:0]  res_q, res_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         n_q    <= '0;
         cnt    <= '0;
         psum_q <= '0;
         res_q  <= '0;
      end else begin
         state  <= state_d;
         n_q    <= n_d;
         cnt    <= cnt_d;
         psum_q <= psum_d;
         res_q  <= res_d;
      end
   end

   always_comb begin
      state_d = state;
      n_d     = n_q;
      cnt_d   = cnt;
      psum_d  = psum_q;
      res_d   = res_q;
      if (clear) begin
         // abort drops any pending result but keeps res_data
         state_d = IDLE;
         cnt_d   = '0;
         psum_d  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && num_chunks != '0) begin
                  state_d = ACC;
                  n_d     = num_chunks;
                  cnt_d   = '0;
                  psum_d  = '0;
               end
            end
            ACC: begin
               if (bus.chunk_valid) begin
                  if (cnt == n_q - 1'b1) begin
                     res_d   = bus.sum;
                     psum_d  = '0;
                     cnt_d   = '0;
                     state_d = OUT;
                  end else begin
                     psum_d = bus.sum;
                     cnt_d  = cnt + 1'b1;
                  end
               end
            end
            OUT: begin
               if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy            = (state != IDLE);
   assign bus.chunk_ready = (state == ACC);
   assign bus.res_valid   = (state == OUT);
   assign bus.sel         = (state == ACC) && (cnt != '0);
   assign bus.psum        = psum_q;
   assign bus.res_data    = res_q;

endmodule
